// File: rtl/hack_cpu_control_pkg.sv
// Shared types and instruction field positions for the Hack control block.
package hack_cpu_control_pkg;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_EXEC    = 3'd3,
    S_WR_WAIT = 3'd4
  } state_t;

  localparam int IR_C    = 15;  // 0 = A-instruction, 1 = C-instruction
  localparam int IR_ABIT = 12;  // ALU y from M instead of A
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DST_A   = 5;
  localparam int DST_D   = 4;
  localparam int DST_M   = 3;
  localparam int JMP_HI  = 2;

endpackage

// File: rtl/cpu_jump_unit.sv
// Hack jump condition evaluation: jump[2]=lt, jump[1]=eq, jump[0]=gt.
module cpu_jump_unit (
  input  logic [2:0] jump,
  input  logic       zr,
  input  logic       ng,
  output logic       take
);

  assign take = (jump[2] & ng) | (jump[1] & zr) | (jump[0] & ~ng & ~zr);

endmodule

// File: rtl/hack_cpu_control.sv
// Multi-cycle Hack CPU control/datapath; the ALU itself sits outside this block.
module hack_cpu_control
  import hack_cpu_control_pkg::*;
#(
  parameter int          PC_W   = 15,
  parameter int unsigned RST_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [15:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [PC_W-1:0] dmem_addr,
  output logic [15:0]     dmem_wdata,
  input  logic            dmem_ack,
  input  logic [15:0]     dmem_rdata,
  output logic [15:0]     alu_x,
  output logic [15:0]     alu_y,
  output logic [5:0]      alu_ctl,
  input  logic [15:0]     alu_out,
  input  logic            alu_zr,
  input  logic            alu_ng,
  output logic [15:0]     dbg_a,
  output logic [15:0]     dbg_d,
  output logic [PC_W-1:0] dbg_pc
);

  state_t          state;
  logic [PC_W-1:0] pc, pc_pend, pc_inc, pc_nxt;
  logic [15:0]     a, d, ir, m;
  logic            take;
  logic            unused_ir;

  cpu_jump_unit u_jump (
    .jump (ir[JMP_HI:0]),
    .zr   (alu_zr),
    .ng   (alu_ng),
    .take (take)
  );

  assign pc_inc    = pc + 1'b1;  // natural wrap at the top of the address space
  assign pc_nxt    = take ? a[PC_W-1:0] : pc_inc;
  assign alu_x     = d;
  assign alu_y     = ir[IR_ABIT] ? m : a;
  assign alu_ctl   = ir[COMP_HI:COMP_LO];
  assign imem_addr = pc;
  assign dbg_a     = a;
  assign dbg_d     = d;
  assign dbg_pc    = pc;
  assign unused_ir = ^ir[14:13];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      pc         <= PC_W'(RST_PC);
      pc_pend    <= '0;
      a          <= '0;
      d          <= '0;
      ir         <= '0;
      m          <= '0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          imem_req <= 1'b1;
          // Fetch completes only against our own request, so stale valids are dropped.
          if (imem_req && imem_valid) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!ir[IR_C]) begin
            a        <= ir;
            pc       <= pc_inc;
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end else if (ir[IR_ABIT]) begin
            dmem_req  <= 1'b1;
            dmem_we   <= 1'b0;
            dmem_addr <= a[PC_W-1:0];
            state     <= S_RD_WAIT;
          end else begin
            state <= S_EXEC;
          end
        end
        S_RD_WAIT: begin
          if (dmem_ack) begin
            m        <= dmem_rdata;
            dmem_req <= 1'b0;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (ir[DST_A]) a <= alu_out;
          if (ir[DST_D]) d <= alu_out;
          // Store address and jump target both use A before this cycle's write.
          if (ir[DST_M]) begin
            dmem_addr  <= a[PC_W-1:0];
            dmem_wdata <= alu_out;
            dmem_we    <= 1'b1;
            dmem_req   <= 1'b1;
            pc_pend    <= pc_nxt;
            state      <= S_WR_WAIT;
          end else begin
            pc       <= pc_nxt;
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_WR_WAIT: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            pc       <= pc_pend;
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
